// File: rtl/seq_div_64by32.sv
// Iterative restoring divider: 64-bit dividend / 32-bit divisor, one quotient bit per clock.
// Optional macro SEQ_DIV_ZERO_FAST_EN adds a div_zero flag and a short path for a zero divisor.
module seq_div_64by32 #(
    parameter int QW = 64,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [QW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] quotient,
    output logic [DW-1:0] remainder
`ifdef SEQ_DIV_ZERO_FAST_EN
    ,
    output logic          div_zero
`endif
);

    localparam int CW = $clog2(QW);
    localparam logic [CW-1:0] LAST_STEP = CW'(QW - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        r_state;
    logic [QW-1:0] r_q;
    logic [DW-1:0] r_d;
    logic [DW-1:0] r_r;
    logic [CW-1:0] r_cnt;
    logic          r_dz;
    logic [DW-1:0] r_lo;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [QW-1:0] r_quot;
    logic [DW-1:0] r_rem;
`ifdef SEQ_DIV_ZERO_FAST_EN
    logic          r_div_zero;
`endif

    logic [DW:0]   w_t;
    logic [DW:0]   w_d_ext;
    logic          w_ge;
    logic [DW-1:0] w_diff;
    logic [DW-1:0] w_r_next;
    logic [QW-1:0] w_q_next;
    logic          w_dvs_zero;

    // A zero divisor is treated as 2^DW so the iteration stays well defined.
    assign w_t        = {r_r, r_q[QW-1]};
    assign w_d_ext    = r_dz ? {1'b1, {DW{1'b0}}} : {1'b0, r_d};
    assign w_ge       = (w_t >= w_d_ext);
    // The true difference is below 2^DW whenever T >= D, so DW bits suffice.
    assign w_diff     = w_t[DW-1:0] - w_d_ext[DW-1:0];
    assign w_r_next   = w_ge ? w_diff : w_t[DW-1:0];
    assign w_q_next   = {r_q[QW-2:0], w_ge};
    assign w_dvs_zero = (divisor == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_q         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            r_dz        <= 1'b0;
            r_lo        <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quot      <= '0;
            r_rem       <= '0;
`ifdef SEQ_DIV_ZERO_FAST_EN
            r_div_zero  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_q        <= dividend;
                        r_d        <= divisor;
                        r_dz       <= w_dvs_zero;
                        r_lo       <= dividend[DW-1:0];
                        r_r        <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
`ifdef SEQ_DIV_ZERO_FAST_EN
                        if (w_dvs_zero) begin
                            r_state    <= DONE;
                            r_quot     <= '1;
                            r_rem      <= dividend[DW-1:0];
                            r_div_zero <= 1'b1;
                        end else begin
                            r_state <= BUSY;
                        end
`else
                        r_state <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    r_q   <= w_q_next;
                    r_r   <= w_r_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_STEP) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_quot      <= r_dz ? {QW{1'b1}} : w_q_next;
                        r_rem       <= r_dz ? r_lo : w_r_next;
                    end
                end
                DONE: begin
                    // The zero-divisor short path enters DONE with out_valid still low.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
`ifdef SEQ_DIV_ZERO_FAST_EN
                        r_div_zero  <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign quotient  = r_quot;
    assign remainder = r_rem;
`ifdef SEQ_DIV_ZERO_FAST_EN
    assign div_zero  = r_div_zero;
`endif

endmodule

// File: tb/tb_seq_div_64by32.sv
// Self-checking bench for seq_div_64by32: directed corner cases plus random back-to-back traffic
// compared against plain 64-bit division. Honours SEQ_DIV_ZERO_FAST_EN when defined.
module tb_seq_div_64by32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] quotient;
    logic [31:0] remainder;
`ifdef SEQ_DIV_ZERO_FAST_EN
    logic        div_zero;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_div_64by32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef SEQ_DIV_ZERO_FAST_EN
        ,
        .div_zero  (div_zero)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_q(input logic [63:0] dvd, input logic [31:0] dvs);
        return (dvs == 32'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : dvd / {32'd0, dvs};
    endfunction

    function automatic logic [63:0] ref_r(input logic [63:0] dvd, input logic [31:0] dvs);
        return (dvs == 32'd0) ? {32'd0, dvd[31:0]} : dvd % {32'd0, dvs};
    endfunction

    function automatic int ref_lat(input logic [31:0] dvs);
`ifdef SEQ_DIV_ZERO_FAST_EN
        return (dvs == 32'd0) ? 1 : 64;
`else
        return (dvs == 32'd0) ? 64 : 64;
`endif
    endfunction

    // One division: accept, wait for result, hold it under backpressure, then consume.
    // nxt_* are presented on the consume edge to show they are not taken there.
    task automatic do_div(input logic [63:0] dvd, input logic [31:0] dvs, input int hold,
                          input logic nxt_valid, input logic [63:0] nxt_dvd, input logic [31:0] nxt_dvs);
        int n;
        check("in_ready_before_accept", in_ready, 1'b1);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        tick;
        in_valid = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = $urandom;
        n = 0;
        while (!out_valid && n < 200) begin
            tick;
            n++;
        end
        $display("div %0h / %0h -> q=%0h r=%0h after %0d edges", dvd, dvs, quotient, remainder, n);
        check("latency", n, ref_lat(dvs));
        check("quotient", quotient, ref_q(dvd, dvs));
        check("remainder", {32'd0, remainder}, ref_r(dvd, dvs));
        check("in_ready_done", in_ready, 1'b0);
`ifdef SEQ_DIV_ZERO_FAST_EN
        check("div_zero", div_zero, dvs == 32'd0);
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            dividend = {$urandom, $urandom};
            divisor  = $urandom;
            tick;
            check("hold_valid", out_valid, 1'b1);
            check("hold_quotient", quotient, ref_q(dvd, dvs));
            check("hold_remainder", {32'd0, remainder}, ref_r(dvd, dvs));
            check("hold_in_ready", in_ready, 1'b0);
        end
        in_valid  = nxt_valid;
        dividend  = nxt_dvd;
        divisor   = nxt_dvs;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("consumed_valid", out_valid, 1'b0);
        check("consumed_in_ready", in_ready, 1'b1);
`ifdef SEQ_DIV_ZERO_FAST_EN
        check("consumed_div_zero", div_zero, 1'b0);
`endif
    endtask

    initial begin
        logic [63:0] q_exp[$];
        logic [63:0] r_exp[$];
        int          lat_exp[$];
        logic        acc, cons;
        logic [63:0] sq, eq, er;
        logic [31:0] sr;
        int          cyc, got, last_cons, lat;

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) tick;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_quotient", quotient, 64'd0);
        check("rst_remainder", {32'd0, remainder}, 64'd0);
        rst = 1'b1;
        tick;
        check("post_rst_in_ready", in_ready, 1'b1);

        do_div(64'd100, 32'd7, 0, 1'b0, 64'd0, 32'd0);
        do_div(64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 0, 1'b0, 64'd0, 32'd0);
        do_div(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 64'd0, 32'd0);
        check("extreme_ref", ref_q(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF), 64'h1_0000_0001);

        // Backpressure: the operands shown on the consume edge are taken one edge later.
        do_div(64'd5, 32'd9, 10, 1'b1, 64'd77777, 32'd3);
        do_div(64'd77777, 32'd3, 0, 1'b0, 64'd0, 32'd0);

        // Asynchronous reset 30 cycles into BUSY.
        in_valid = 1'b1;
        dividend = 64'hDEAD_BEEF_0123_4567;
        divisor  = 32'd12345;
        tick;
        in_valid = 1'b0;
        repeat (30) tick;
        #2 rst = 1'b0;
        #1;
        $display("async reset mid-division: q=%0h r=%0h out_valid=%0b in_ready=%0b",
                 quotient, remainder, out_valid, in_ready);
        check("midrst_quotient", quotient, 64'd0);
        check("midrst_remainder", {32'd0, remainder}, 64'd0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        tick;
        rst = 1'b1;
        repeat (70) tick;
        check("midrst_no_result", out_valid, 1'b0);
        do_div(64'd1000, 32'd10, 0, 1'b0, 64'd0, 32'd0);

        do_div(64'h1234_5678_9ABC_DEF0, 32'd0, 2, 1'b0, 64'd0, 32'd0);

        // Random back-to-back traffic with in_valid and out_ready held high.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        dividend  = {$urandom, $urandom};
        divisor   = $urandom;
        cyc       = 0;
        got       = 0;
        last_cons = -1;
        while (got < 200 && cyc < 20000) begin
            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            sq   = quotient;
            sr   = remainder;
            tick;
            cyc++;
            if (acc) begin
                q_exp.push_back(ref_q(dividend, divisor));
                r_exp.push_back(ref_r(dividend, divisor));
                lat_exp.push_back(ref_lat(divisor));
                dividend = {$urandom, $urandom};
                case ($urandom_range(7))
                    0:       divisor = 32'd0;
                    1:       divisor = $urandom_range(15);
                    2:       begin divisor = $urandom; dividend = 64'($urandom_range(1000)); end
                    default: divisor = $urandom;
                endcase
            end
            if (cons) begin
                if (q_exp.size() == 0) begin
                    check("rand_unexpected_result", 1'b1, 1'b0);
                end else begin
                    eq  = q_exp.pop_front();
                    er  = r_exp.pop_front();
                    lat = lat_exp.pop_front();
                    $display("rand #%0d q=%0h r=%0h exp q=%0h r=%0h", got, sq, sr, eq, er);
                    check("rand_quotient", sq, eq);
                    check("rand_remainder", {32'd0, sr}, er);
                    if (last_cons >= 0) check("rand_interval", cyc - last_cons, lat + 2);
                end
                last_cons = cyc;
                got++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rand_result_count", got, 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
